// File: rtl/ws2812_rx_decoder.sv
// WS2812 one-wire receiver: classifies high-pulse widths into bits, assembles 24-bit GRB words,
// tracks LED index per frame, detects the latch gap and reports malformed traffic.
module ws2812_rx_decoder #(
    parameter  int CLK_FREQ_HZ = 50_000_000,
    parameter  int T_BIT_NS    = 600,
    parameter  int T_MIN_NS    = 100,
    parameter  int T_MAXH_NS   = 5000,
    parameter  int T_RESET_NS  = 50000,
    parameter  int MAX_LEDS    = 64,
    localparam int IW          = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    output logic [23:0]   pix_data,
    output logic          pix_valid,
    output logic [IW-1:0] pix_index,
    output logic          frame_done,
    output logic          err_pulse,
    output logic          busy
);

    localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int THRESH_CYC = CYC_PER_US * T_BIT_NS   / 1000;
    localparam int MIN_CYC    = CYC_PER_US * T_MIN_NS   / 1000;
    localparam int MAXH_CYC   = CYC_PER_US * T_MAXH_NS  / 1000;
    localparam int RESET_CYC  = CYC_PER_US * T_RESET_NS / 1000;
    localparam int CW         = $clog2(RESET_CYC + 1);
    localparam int PW         = $clog2(MAX_LEDS + 1);

    localparam logic [CW-1:0] THRESH_C = CW'(THRESH_CYC);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_CYC);
    localparam logic [CW-1:0] MAXH_C   = CW'(MAXH_CYC);
    localparam logic [CW-1:0] RESET_C  = CW'(RESET_CYC);
    localparam logic [PW-1:0] MAX_C    = PW'(MAX_LEDS);

    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t        r_state;
    logic          r_meta;
    logic          r_din_s;
    logic          r_din_d;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_bitcnt;
    logic [PW-1:0] r_pixcnt;
    logic [22:0]   r_shift;

    logic          w_rise;
    logic          w_fall;
    logic          w_bit;
    logic          w_last;
    logic [23:0]   w_word;
    logic [CW-1:0] w_cnt_inc;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_din_s <= 1'b0;
            r_din_d <= 1'b0;
        end else begin
            r_meta  <= din;
            r_din_s <= r_meta;
            r_din_d <= r_din_s;
        end
    end

    assign w_rise    = r_din_s & ~r_din_d;
    assign w_fall    = ~r_din_s & r_din_d;
    assign w_bit     = (r_cnt >= THRESH_C);
    assign w_last    = (r_bitcnt == 5'd23);
    assign w_word    = {r_shift, w_bit};
    assign w_cnt_inc = (r_cnt == RESET_C) ? r_cnt : r_cnt + CW'(1);

    // r_cnt holds the length of the current din_s level in cycles (1 on the edge cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_SYNC;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_pixcnt   <= '0;
            r_shift    <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_index  <= '0;
            frame_done <= 1'b0;
            err_pulse  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            err_pulse  <= 1'b0;
            case (r_state)
                S_SYNC: begin
                    r_cnt <= r_din_s ? '0 : w_cnt_inc;
                    if (!r_din_s && (r_cnt == RESET_C)) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_HIGH;
                        r_cnt   <= CW'(1);
                        busy    <= 1'b1;
                    end
                end
                S_HIGH: begin
                    r_cnt <= w_fall ? CW'(1) : w_cnt_inc;
                    if (w_fall && (r_cnt < MIN_C)) begin
                        err_pulse <= 1'b1;
                        r_state   <= S_SYNC;
                        busy      <= 1'b0;
                        r_cnt     <= '0;
                        r_bitcnt  <= '0;
                        r_pixcnt  <= '0;
                        r_shift   <= '0;
                    end else if (w_fall) begin
                        r_shift <= w_word[22:0];
                        r_state <= S_LOW;
                        if (w_last) begin
                            r_bitcnt <= '0;
                            if (r_pixcnt == MAX_C) begin
                                err_pulse <= 1'b1;
                            end else begin
                                pix_valid <= 1'b1;
                                pix_data  <= w_word;
                                pix_index <= r_pixcnt[IW-1:0];
                                r_pixcnt  <= r_pixcnt + PW'(1);
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 5'd1;
                        end
                    end else if (r_cnt >= MAXH_C) begin
                        err_pulse <= 1'b1;
                        r_state   <= S_SYNC;
                        busy      <= 1'b0;
                        r_cnt     <= '0;
                        r_bitcnt  <= '0;
                        r_pixcnt  <= '0;
                        r_shift   <= '0;
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        r_state <= S_HIGH;
                        r_cnt   <= CW'(1);
                    end else if (r_cnt == RESET_C) begin
                        err_pulse  <= (r_bitcnt != 5'd0);
                        frame_done <= (r_pixcnt != '0);
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                        r_bitcnt   <= '0;
                        r_pixcnt   <= '0;
                        r_shift    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_SYNC;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
